map_ram_arbiter: RTL and testbench
==================================

Name: map_ram_arbiter

Overview:
- Shares the 1200x8 single-port tile-map RAM (40 columns x 30 rows, 1-cycle read latency) between two requesters: the video tile-fetch engine (priority) and the HPS Avalon-MM slave port (read/write).
- Converts video (row, col) requests into linear RAM addresses and guarantees the CPU forward progress through a starvation limiter.
- Sits between the host bridge / video pipeline and the map RAM's slave port.

Parameters:
- MAP_COLS, 40, tiles per row.
- MAP_ROWS, 30, rows; RAM depth = MAP_COLS*MAP_ROWS = 1200.
- STARVE_LIMIT, 8, consecutive denied CPU cycles before the CPU is forced a slot (1..255).
- OOR_TILE, 8'h00, tile value returned for out-of-range requests.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vid_req  in  1  video fetch request
- vid_row  in  5  tile row
- vid_col  in  6  tile column
- vid_ready  out  1  video request accepted this cycle (combinational)
- vid_valid  out  1  video read data valid
- vid_data  out  8  video tile value
- avs_address  in  11  CPU linear map address
- avs_read  in  1  CPU read
- avs_write  in  1  CPU write
- avs_writedata  in  8  CPU write data
- avs_waitrequest  out  1  CPU stall (combinational)
- avs_readdata  out  8  CPU read data
- avs_readdatavalid  out  1  CPU read data valid
- ram_address  out  11  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  8  to RAM
- ram_clken  out  1  to RAM; constant 1
- ram_readdata  in  8  from RAM, valid the cycle after the address is issued

Behaviour:
- One RAM access per cycle. Grant is decided combinationally each cycle:
  - vid_req and starve_cnt < STARVE_LIMIT: video.
  - Otherwise, avs_read or avs_write: CPU.
  - Otherwise: idle, with ram_chipselect=0.
- Video slot:
  - vid_ready=1.
  - ram_address = vid_row*40 + vid_col, computed as (row<<5)+(row<<3)+col in 11 bits.
  - Registers rd_src=VID.
  - If vid_row>=MAP_ROWS or vid_col>=MAP_COLS: ram_chipselect=0 and rd_src=VID_OOR.
- CPU slot:
  - avs_waitrequest=0, else 1 whenever CPU is pending.
  - Write: ram_chipselect=1, ram_write=1, data and address passed through. Addresses >=1200 are dropped (chipselect 0) but still acknowledged.
  - Read: rd_src=CPU, or CPU_OOR if address >=1200.
  - avs_read and avs_write both high: treat as write.
- Return stage, the cycle after the grant (registered):
  - VID: vid_valid=1, vid_data=ram_readdata.
  - VID_OOR: vid_valid=1, vid_data=OOR_TILE.
  - CPU: avs_readdatavalid=1, avs_readdata=ram_readdata.
  - CPU_OOR: avs_readdatavalid=1, avs_readdata=8'h00.
  - Valids are single-cycle pulses; data holds its last value.
- Latency: exactly 1 cycle from accept to valid for both requesters. The video side can be fully pipelined (one accept per cycle).
- Starvation counter starve_cnt (8 bits, saturating):
  - Increments each cycle CPU is pending and not granted.
  - Clears on CPU grant or when CPU is not pending.
  - On reaching STARVE_LIMIT, the next cycle goes to the CPU and vid_ready=0 for that cycle.
- Read-during-write collisions are impossible (single grant). A CPU write followed by a video read of the same address returns the new value.
- Reset (async assert):
  - vid_valid=0, vid_data=0, avs_readdatavalid=0, avs_readdata=0, starve_cnt=0, rd_src=NONE.
  - While reset is high: ram_chipselect=0, ram_write=0, vid_ready=0, avs_waitrequest=1.
  - An in-flight read is discarded; no valid is issued after reset deasserts.

Test Plan:
- Video stream: rows 0..1, cols 0..39 on consecutive cycles with RAM preloaded addr[7:0] -> vid_ready every cycle; vid_valid 1 cycle later; (row1,col5) returns address 45 data 8'h2D.
- CPU write then video read: write 8'hA5 to address 1199, then video read (29,39) -> avs_waitrequest low for 1 cycle; vid_data=8'hA5.
- Contention, STARVE_LIMIT=4: vid_req held high, CPU read of address 10 -> waitrequest high 4 cycles; grant on 5th cycle with vid_ready=0; avs_readdatavalid next cycle with RAM[10].
- Out of range: video (30,0) and (0,40), CPU read at 1200, CPU write at 2047 -> ram_chipselect=0 on those cycles; vid_data=OOR_TILE, avs_readdata=0; RAM contents unchanged.
- Reset mid-read: assert reset in the cycle after a CPU read grant -> avs_readdatavalid stays 0; all registered outputs 0; waitrequest=1 during reset.
- Idle: no requests for 10 cycles -> ram_chipselect=0 and starve_cnt=0 throughout.

Source files
------------

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single-port tile-map RAM between the video
// tile-fetch engine (priority) and the HPS Avalon-MM slave. A saturating
// starvation counter forces a CPU slot after STARVE_LIMIT denied cycles.
module map_ram_arbiter #(
  parameter int          MAP_COLS     = 40,
  parameter int          MAP_ROWS     = 30,
  parameter int          STARVE_LIMIT = 8,
  parameter logic [7:0]  OOR_TILE     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [4:0]  vid_row,
  input  logic [5:0]  vid_col,
  output logic        vid_ready,
  output logic        vid_valid,
  output logic [7:0]  vid_data,
  input  logic [10:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [7:0]  avs_writedata,
  output logic        avs_waitrequest,
  output logic [7:0]  avs_readdata,
  output logic        avs_readdatavalid,
  output logic [10:0] ram_address,
  output logic        ram_chipselect,
  output logic        ram_write,
  output logic [7:0]  ram_writedata,
  output logic        ram_clken,
  input  logic [7:0]  ram_readdata
);

  localparam logic [5:0]  ROWS_L  = 6'(MAP_ROWS);
  localparam logic [6:0]  COLS_L  = 7'(MAP_COLS);
  localparam logic [11:0] DEPTH_L = 12'(MAP_COLS * MAP_ROWS);
  localparam logic [7:0]  LIMIT_L = 8'(STARVE_LIMIT);

  // Origin of the read whose data returns in the current cycle.
  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_VID,
    SRC_VID_OOR,
    SRC_CPU,
    SRC_CPU_OOR
  } src_t;

  src_t        rd_src;
  src_t        src_next;
  logic [7:0]  starve_cnt;
  logic [7:0]  vid_hold;
  logic [7:0]  cpu_hold;
  logic        cpu_pend;
  logic        cpu_grant;
  logic        vid_in_range;
  logic        cpu_in_range;
  logic [10:0] vid_lin;

  // The linear address uses the row*40 = (row<<5)+(row<<3) shift-add form,
  // so the map width of 40 columns is baked into this datapath.
  assign vid_lin      = {1'b0, vid_row, 5'b0} + {3'b0, vid_row, 3'b0} + {5'b0, vid_col};
  assign vid_in_range = ({1'b0, vid_row} < ROWS_L) && ({1'b0, vid_col} < COLS_L);
  assign cpu_in_range = ({1'b0, avs_address} < DEPTH_L);
  assign cpu_pend     = avs_read | avs_write;
  assign ram_writedata = avs_writedata;
  assign ram_clken     = 1'b1;

  // Single-grant arbitration: video wins unless the CPU has starved long enough.
  always_comb begin
    vid_ready       = 1'b0;
    avs_waitrequest = reset | cpu_pend;
    ram_address     = 11'd0;
    ram_chipselect  = 1'b0;
    ram_write       = 1'b0;
    cpu_grant       = 1'b0;
    src_next        = SRC_NONE;
    if (!reset) begin
      if (vid_req && (starve_cnt < LIMIT_L)) begin
        vid_ready      = 1'b1;
        ram_address    = vid_lin;
        ram_chipselect = vid_in_range;
        src_next       = vid_in_range ? SRC_VID : SRC_VID_OOR;
      end else if (cpu_pend) begin
        cpu_grant       = 1'b1;
        avs_waitrequest = 1'b0;
        ram_address     = avs_address;
        ram_chipselect  = cpu_in_range;
        if (avs_write) begin
          ram_write = cpu_in_range;
        end else begin
          src_next = cpu_in_range ? SRC_CPU : SRC_CPU_OOR;
        end
      end
    end
  end

  // Count consecutive cycles the CPU waits; any grant or idle CPU clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (!cpu_pend || cpu_grant) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Remember who owns the RAM read data arriving next cycle; reset drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_src <= SRC_NONE;
    end else begin
      rd_src <= src_next;
    end
  end

  // Return stage: RAM data lands the cycle after the grant, giving a
  // one-cycle accept-to-valid latency; data holds between valids.
  always_comb begin
    vid_valid         = (rd_src == SRC_VID) || (rd_src == SRC_VID_OOR);
    avs_readdatavalid = (rd_src == SRC_CPU) || (rd_src == SRC_CPU_OOR);
    vid_data          = vid_hold;
    avs_readdata      = cpu_hold;
    if (rd_src == SRC_VID)     vid_data     = ram_readdata;
    if (rd_src == SRC_VID_OOR) vid_data     = OOR_TILE;
    if (rd_src == SRC_CPU)     avs_readdata = ram_readdata;
    if (rd_src == SRC_CPU_OOR) avs_readdata = 8'h00;
  end

  // Hold registers keep the last returned values visible between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_hold <= 8'h00;
      cpu_hold <= 8'h00;
    end else begin
      vid_hold <= vid_data;
      cpu_hold <= avs_readdata;
    end
  end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb_map_ram_arbiter: table-driven vectors plus hand-written sequences,
// with a behavioural map RAM and a scoreboard for returned read data.
module tb_map_ram_arbiter;

  localparam logic [7:0] OOR = 8'hEE;
  localparam int DEPTH = 1200;

  logic        clk;
  logic        reset;
  logic        vid_req;
  logic [4:0]  vid_row;
  logic [5:0]  vid_col;
  logic        vid_ready;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic [10:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [7:0]  avs_writedata;
  logic        avs_waitrequest;
  logic [7:0]  avs_readdata;
  logic        avs_readdatavalid;
  logic [10:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [7:0]  ram_writedata;
  logic        ram_clken;
  logic [7:0]  ram_readdata;

  map_ram_arbiter #(
    .MAP_COLS(40), .MAP_ROWS(30), .STARVE_LIMIT(4), .OOR_TILE(OOR)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_row(vid_row), .vid_col(vid_col),
    .vid_ready(vid_ready), .vid_valid(vid_valid), .vid_data(vid_data),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, 1-cycle read latency, preloaded addr[7:0].
  logic [7:0] mem [0:2047];
  logic       oor_write_seen;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
    ram_readdata   = 8'h00;
    oor_write_seen = 1'b0;
  end
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        if (ram_address < 11'(DEPTH)) mem[ram_address] <= ram_writedata;
        else oor_write_seen <= 1'b1;
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  // Reference copy of the map contents, updated only by expected writes.
  logic [7:0] ref_mem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i);

  int checks = 0;
  int errors = 0;
  logic [7:0] vid_q [$];
  logic [7:0] cpu_q [$];
  logic [7:0] last_vid = 8'h00;
  logic [7:0] last_cpu = 8'h00;

  typedef struct {
    logic        vreq;
    logic [4:0]  row;
    logic [5:0]  col;
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic        exp_ready;
    logic        exp_wait;
    logic        exp_cs;
    logic        exp_we;
    logic [10:0] exp_addr;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic vreq, logic [4:0] row, logic [5:0] col,
                              logic rd, logic wr, logic [10:0] addr, logic [7:0] wdata,
                              logic er, logic ew, logic ecs, logic ewe, logic [10:0] ea);
    vec_t v;
    v.vreq = vreq; v.row = row; v.col = col; v.rd = rd; v.wr = wr;
    v.addr = addr; v.wdata = wdata; v.exp_ready = er; v.exp_wait = ew;
    v.exp_cs = ecs; v.exp_we = ewe; v.exp_addr = ea;
    return v;
  endfunction

  function automatic vec_t idle_vec();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    vid_req       = v.vreq;
    vid_row       = v.row;
    vid_col       = v.col;
    avs_read      = v.rd;
    avs_write     = v.wr;
    avs_address   = v.addr;
    avs_writedata = v.wdata;
  endtask

  // Samples combinational outputs mid-cycle, predicts returned data, then
  // advances to just after the next rising edge.
  task automatic checkOutput(input vec_t v, input bit push);
    int lin;
    @(negedge clk);
    checkVal("vid_ready", 32'(vid_ready), 32'(v.exp_ready));
    checkVal("avs_waitrequest", 32'(avs_waitrequest), 32'(v.exp_wait));
    checkVal("ram_chipselect", 32'(ram_chipselect), 32'(v.exp_cs));
    if (v.exp_cs) begin
      checkVal("ram_address", 32'(ram_address), 32'(v.exp_addr));
      checkVal("ram_write", 32'(ram_write), 32'(v.exp_we));
    end
    if (push) begin
      if (v.vreq && v.exp_ready) begin
        lin = int'(v.row) * 40 + int'(v.col);
        if (v.row < 5'd30 && v.col < 6'd40) vid_q.push_back(ref_mem[lin]);
        else vid_q.push_back(OOR);
      end
      if ((v.rd || v.wr) && !v.exp_wait) begin
        if (v.wr) begin
          if (v.addr < 11'(DEPTH)) ref_mem[v.addr] = v.wdata;
        end else begin
          cpu_q.push_back(v.addr < 11'(DEPTH) ? ref_mem[v.addr] : 8'h00);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput(v, 1'b1);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (vid_valid) begin
      if (vid_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL vid_valid_unexpected actual=1 expected=0 at %0t", $time);
      end else begin
        last_vid = vid_q.pop_front();
        checkVal("vid_data", 32'(vid_data), 32'(last_vid));
      end
    end
    if (avs_readdatavalid) begin
      if (cpu_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL avs_readdatavalid_unexpected actual=1 expected=0 at %0t", $time);
      end else begin
        last_cpu = cpu_q.pop_front();
        checkVal("avs_readdata", 32'(avs_readdata), 32'(last_cpu));
      end
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(mk(1, 0, 0, 1, 0, 11'd10, 0, 0, 0, 0, 0, 0));

    // Reset state, with both requesters asking.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_vid_ready", 32'(vid_ready), 0);
    checkVal("rst_waitrequest", 32'(avs_waitrequest), 1);
    checkVal("rst_chipselect", 32'(ram_chipselect), 0);
    checkVal("rst_ram_write", 32'(ram_write), 0);
    checkVal("rst_vid_valid", 32'(vid_valid), 0);
    checkVal("rst_vid_data", 32'(vid_data), 0);
    checkVal("rst_readdatavalid", 32'(avs_readdatavalid), 0);
    checkVal("rst_readdata", 32'(avs_readdata), 0);
    checkVal("rst_clken", 32'(ram_clken), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(idle_vec());

    // Vector table: video stream, write/read-back, both-high, out-of-range.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 40; c++)
        tbl.push_back(mk(1, 5'(r), 6'(c), 0, 0, 0, 0, 1, 0, 1, 0, 11'(r * 40 + c)));
    tbl.push_back(mk(0, 0, 0, 0, 1, 11'd1199, 8'hA5, 0, 0, 1, 1, 11'd1199));
    tbl.push_back(mk(1, 5'd29, 6'd39, 0, 0, 0, 0, 1, 0, 1, 0, 11'd1199));
    tbl.push_back(mk(0, 0, 0, 1, 1, 11'd100, 8'h5A, 0, 0, 1, 1, 11'd100));
    tbl.push_back(mk(1, 5'd2, 6'd20, 0, 0, 0, 0, 1, 0, 1, 0, 11'd100));
    tbl.push_back(mk(1, 5'd30, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 11'd1200));
    tbl.push_back(mk(1, 5'd0, 6'd40, 0, 0, 0, 0, 1, 0, 0, 0, 11'd40));
    tbl.push_back(mk(0, 0, 0, 1, 0, 11'd1200, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 11'd2047, 8'h77, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 11'd1199, 0, 0, 0, 1, 0, 11'd1199));
    tbl.push_back(mk(1, 5'd1, 6'd5, 0, 0, 0, 0, 1, 0, 1, 0, 11'd45));
    tbl.push_back(mk(0, 0, 0, 1, 0, 11'd45, 0, 0, 0, 1, 0, 11'd45));
    tbl.push_back(idle_vec());
    foreach (tbl[i]) step(tbl[i]);
    checkVal("no_oor_ram_write", 32'(oor_write_seen), 0);
    checkVal("ram_1199_contents", 32'(mem[1199]), 32'h A5);

    // Contention: video holds the RAM for STARVE_LIMIT cycles, then CPU wins.
    for (int i = 0; i < 4; i++)
      step(mk(1, 5'd1, 6'd5, 1, 0, 11'd10, 0, 1, 1, 1, 0, 11'd45));
    step(mk(1, 5'd1, 6'd5, 1, 0, 11'd10, 0, 0, 0, 1, 0, 11'd10));
    step(mk(1, 5'd0, 6'd1, 0, 0, 0, 0, 1, 0, 1, 0, 11'd1));

    // Idle: nothing requested, counter stays clear, outputs hold last data.
    for (int i = 0; i < 10; i++) begin
      step(idle_vec());
      checkVal("idle_starve_cnt", 32'(dut.starve_cnt), 0);
    end
    checkVal("hold_vid_data", 32'(vid_data), 32'(last_vid));
    checkVal("hold_readdata", 32'(avs_readdata), 32'(last_cpu));
    checkVal("vid_q_drained", 32'(vid_q.size()), 0);
    checkVal("cpu_q_drained", 32'(cpu_q.size()), 0);

    // Reset the cycle after a CPU read grant: the read must never complete.
    applyStimulus(mk(0, 0, 0, 1, 0, 11'd10, 0, 0, 0, 1, 0, 11'd10));
    checkOutput(mk(0, 0, 0, 1, 0, 11'd10, 0, 0, 0, 1, 0, 11'd10), 1'b0);
    reset = 1'b1;
    applyStimulus(mk(1, 5'd0, 6'd2, 1, 0, 11'd10, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkVal("mid_rst_readdatavalid", 32'(avs_readdatavalid), 0);
      checkVal("mid_rst_readdata", 32'(avs_readdata), 0);
      checkVal("mid_rst_vid_data", 32'(vid_data), 0);
      checkVal("mid_rst_waitrequest", 32'(avs_waitrequest), 1);
      checkVal("mid_rst_vid_ready", 32'(vid_ready), 0);
      checkVal("mid_rst_chipselect", 32'(ram_chipselect), 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    applyStimulus(idle_vec());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("post_rst_readdatavalid", 32'(avs_readdatavalid), 0);
      @(posedge clk);
      #1;
    end

    // A fresh read after reset behaves normally.
    step(mk(0, 0, 0, 1, 0, 11'd7, 0, 0, 0, 1, 0, 11'd7));
    step(idle_vec());
    step(idle_vec());
    checkVal("final_vid_q_empty", 32'(vid_q.size()), 0);
    checkVal("final_cpu_q_empty", 32'(cpu_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
